// File: rtl/sdram_pkg.sv
// sdram_pkg: shared constants, FSM state type, latched command type and
// the address-alignment helper used by sdram_line_master.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic                    wr;
    logic                    line;
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [3:0]              be;
  } sdram_cmd_t;

  // Clear the low_bits least significant bits of a byte address.
  function automatic logic [SDRAM_ADDR_W-1:0] align_addr(
    input logic [SDRAM_ADDR_W-1:0] addr,
    input int unsigned             low_bits
  );
    logic [SDRAM_ADDR_W-1:0] mask;
    mask = ~((SDRAM_ADDR_W'(1) << low_bits) - SDRAM_ADDR_W'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/sdram_line_master_if.sv
// sdram_line_master_if: one requester port of the SDRAM x2 controller.
// The master modport is the line master, the slave modport is the controller.
interface sdram_line_master_if;
  import sdram_pkg::*;

  logic                    sd_req;
  logic                    sd_ack;
  logic                    sd_wr;
  logic [SDRAM_ADDR_W-1:0] sd_addr;
  logic [SDRAM_DATA_W-1:0] sd_din;
  logic [SDRAM_DATA_W-1:0] sd_dout;
  logic [3:0]              sd_be;
  logic [3:0]              sd_burst_cnt;
  logic                    sd_ready;
  logic                    sd_burst_done;

  modport master (
    output sd_req, sd_wr, sd_addr, sd_din, sd_be, sd_burst_cnt,
    input  sd_ack, sd_ready, sd_dout, sd_burst_done
  );

  modport slave (
    input  sd_req, sd_wr, sd_addr, sd_din, sd_be, sd_burst_cnt,
    output sd_ack, sd_ready, sd_dout, sd_burst_done
  );

endinterface

// File: rtl/sdram_line_master.sv
// sdram_line_master: turns a single-cycle cache command (line fill, line
// writeback or one masked word) into the SDRAM port handshake, streams the
// burst words and returns one done pulse with the whole line.
// Optional build macro SDRAM_LINE_MASTER_TIMEOUT_EN: abort a transfer that
// makes no progress for TIMEOUT_CYCLES clocks (done with err=1).
module sdram_line_master
  import sdram_pkg::*;
#(
  parameter int LINE_WORDS     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_wr,
  input  logic                               cmd_line,
  input  logic [SDRAM_ADDR_W-1:0]            cmd_addr,
  input  logic [3:0]                         cmd_be,
  input  logic [LINE_WORDS*SDRAM_DATA_W-1:0] cmd_wdata,
  output logic                               done,
  output logic                               err,
  output logic [LINE_WORDS*SDRAM_DATA_W-1:0] rdata,
  sdram_line_master_if.master                sd
);

  // Byte offset bits covered by one line, and word index width.
  localparam int OFS_W = $clog2(LINE_WORDS * 4);
  localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  // Parameter sanity: burst counter is 4 bits, timeout needs at least one cycle.
  if (LINE_WORDS < 1 || LINE_WORDS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_config
  end

  state_t                                   state_r;
  logic [3:0]                               cnt_r;
  logic                                     wr_r;
  logic                                     ovf_r;
  logic [LINE_WORDS-1:0][SDRAM_DATA_W-1:0]  wdata_r;
  logic [LINE_WORDS-1:0][SDRAM_DATA_W-1:0]  rdata_r;

  sdram_cmd_t cmd_s;
  logic       take_s;
  logic [3:0] cnt_nxt_s;
  logic [3:0] nxt_idx_s;
  logic       ovf_nxt_s;
  logic       tmo_hit_s;

  assign rdata = rdata_r;

  // Beat bookkeeping: a ready counts only while the burst still has room.
  always_comb begin
    cmd_s.wr   = cmd_wr;
    cmd_s.line = cmd_line;
    cmd_s.addr = cmd_addr;
    cmd_s.be   = cmd_be;
    take_s     = 1'b0;
    if (state_r == XFER && sd.sd_ready && (cnt_r < sd.sd_burst_cnt)) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
    cnt_nxt_s = cnt_r + {3'b000, take_s};
    nxt_idx_s = cnt_r + 4'd1;
    ovf_nxt_s = ovf_r | ((state_r == XFER) & sd.sd_ready & ~take_s);
  end

`ifdef SDRAM_LINE_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_r;

  assign tmo_hit_s = ((state_r == REQ) || (state_r == XFER)) &&
                     (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: runs while waiting on the controller, cleared on progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_r <= '0;
    end else begin
      case (state_r)
        REQ: begin
          if (sd.sd_ack || tmo_hit_s) tmo_r <= '0;
          else                        tmo_r <= tmo_r + TMO_W'(1);
        end
        XFER: begin
          if (sd.sd_ready || sd.sd_burst_done || tmo_hit_s) tmo_r <= '0;
          else                                              tmo_r <= tmo_r + TMO_W'(1);
        end
        default: tmo_r <= '0;
      endcase
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Main FSM: IDLE -> REQ -> XFER -> DONE -> IDLE, all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      cmd_ready       <= 1'b1;
      done            <= 1'b0;
      err             <= 1'b0;
      rdata_r         <= '0;
      wdata_r         <= '0;
      cnt_r           <= 4'd0;
      wr_r            <= 1'b0;
      ovf_r           <= 1'b0;
      sd.sd_req       <= 1'b0;
      sd.sd_wr        <= 1'b0;
      sd.sd_addr      <= '0;
      sd.sd_din       <= '0;
      sd.sd_be        <= 4'h0;
      sd.sd_burst_cnt <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (cmd_valid) begin
            state_r         <= REQ;
            cmd_ready       <= 1'b0;
            wr_r            <= cmd_s.wr;
            wdata_r         <= cmd_wdata;
            rdata_r         <= '0;
            cnt_r           <= 4'd0;
            ovf_r           <= 1'b0;
            sd.sd_req       <= 1'b1;
            sd.sd_wr        <= cmd_s.wr;
            sd.sd_addr      <= cmd_s.line ? align_addr(cmd_s.addr, OFS_W)
                                          : align_addr(cmd_s.addr, 2);
            sd.sd_burst_cnt <= cmd_s.line ? 4'(LINE_WORDS) : 4'd1;
            sd.sd_be        <= (cmd_s.wr && !cmd_s.line) ? cmd_s.be : 4'hF;
            sd.sd_din       <= cmd_wdata[SDRAM_DATA_W-1:0];
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        REQ: begin
          if (sd.sd_ack) begin
            sd.sd_req <= 1'b0;
            state_r   <= XFER;
          end else if (tmo_hit_s) begin
            sd.sd_req <= 1'b0;
            state_r   <= DONE;
            done      <= 1'b1;
            err       <= 1'b1;
          end else begin
            sd.sd_req <= 1'b1;
          end
        end
        XFER: begin
          if (take_s) begin
            cnt_r <= cnt_nxt_s;
            if (wr_r) begin
              // The controller consumed sd_din; present the next word.
              if (nxt_idx_s < 4'(LINE_WORDS)) begin
                sd.sd_din <= wdata_r[nxt_idx_s[IDX_W-1:0]];
              end
            end else begin
              rdata_r[cnt_r[IDX_W-1:0]] <= sd.sd_dout;
            end
          end
          ovf_r <= ovf_nxt_s;
          // A ready coinciding with burst_done is already in cnt_nxt_s.
          if (sd.sd_burst_done) begin
            state_r <= DONE;
            done    <= 1'b1;
            err     <= ovf_nxt_s | (cnt_nxt_s != sd.sd_burst_cnt);
          end else if (tmo_hit_s) begin
            state_r <= DONE;
            done    <= 1'b1;
            err     <= 1'b1;
          end
        end
        DONE: begin
          done      <= 1'b0;
          err       <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          cmd_ready <= 1'b1;
          done      <= 1'b0;
          err       <= 1'b0;
          sd.sd_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_line_master.sv
// tb_sdram_line_master: directed bench acting as the SDRAM controller port.
// Expected completions are queued when a command is issued and checked
// when done pulses.
module tb_sdram_line_master;
  import sdram_pkg::*;

  localparam int LW = 4;
  localparam int DW = LW * 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_wr = 1'b0;
  logic          cmd_line = 1'b0;
  logic [24:0]   cmd_addr = 25'h0;
  logic [3:0]    cmd_be = 4'h0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready;
  logic          done;
  logic          err;
  logic [DW-1:0] rdata;

  sdram_line_master_if sd_bus();

  sdram_line_master #(.LINE_WORDS(LW), .TIMEOUT_CYCLES(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_line  (cmd_line),
    .cmd_addr  (cmd_addr),
    .cmd_be    (cmd_be),
    .cmd_wdata (cmd_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .sd        (sd_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          err;
    logic          chk_rdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic line, input logic [24:0] a,
                       input logic [3:0] be, input logic [DW-1:0] wd,
                       input logic exp_err, input logic chk, input logic [DW-1:0] exp_rd);
    exp_t e;
    check("cmd_ready_before_issue", DW'(cmd_ready), DW'(1'b1));
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_line  = line;
    cmd_addr  = a;
    cmd_be    = be;
    cmd_wdata = wd;
    e.err = exp_err;
    e.chk_rdata = chk;
    e.rdata = exp_rd;
    sb.push_back(e);
    tick();
    cmd_valid = 1'b0;
    check("req_after_accept", DW'(sd_bus.sd_req), DW'(1'b1));
  endtask

  task automatic ack_now();
    sd_bus.sd_ack = 1'b1;
    tick();
    sd_bus.sd_ack = 1'b0;
    check("req_drop_on_ack", DW'(sd_bus.sd_req), DW'(1'b0));
  endtask

  task automatic beat(input logic [31:0] d, input logic bd);
    sd_bus.sd_ready      = 1'b1;
    sd_bus.sd_dout       = d;
    sd_bus.sd_burst_done = bd;
    tick();
    sd_bus.sd_ready      = 1'b0;
    sd_bus.sd_burst_done = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    exp_t e;
    check({tag, "_done"}, DW'(done), DW'(1'b1));
    check({tag, "_sb_depth"}, DW'(sb.size()), DW'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_err"}, DW'(err), DW'(e.err));
      if (e.chk_rdata) check({tag, "_rdata"}, rdata, e.rdata);
    end
    tick();
    check({tag, "_done_one_cycle"}, DW'(done), DW'(1'b0));
    check({tag, "_ready_after"}, DW'(cmd_ready), DW'(1'b1));
  endtask

  initial begin
    logic [31:0] w [4];
    int k;
    int n;
    sd_bus.sd_ack        = 1'b0;
    sd_bus.sd_ready      = 1'b0;
    sd_bus.sd_dout       = 32'h0;
    sd_bus.sd_burst_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    check("rst_cmd_ready", DW'(cmd_ready), DW'(1'b1));
    check("rst_done", DW'(done), DW'(1'b0));
    check("rst_err", DW'(err), DW'(1'b0));
    check("rst_rdata", rdata, '0);
    check("rst_sd_req", DW'(sd_bus.sd_req), DW'(1'b0));
    check("rst_sd_wr", DW'(sd_bus.sd_wr), DW'(1'b0));
    check("rst_sd_addr", DW'(sd_bus.sd_addr), DW'(25'h0));
    check("rst_sd_din", DW'(sd_bus.sd_din), DW'(32'h0));
    check("rst_sd_be", DW'(sd_bus.sd_be), DW'(4'h0));
    check("rst_sd_bcnt", DW'(sd_bus.sd_burst_cnt), DW'(4'h0));
    reset = 1'b0;
    tick();

    // Stray ready/burst_done in IDLE are ignored
    beat(32'hBAD0BAD0, 1'b1);
    check("idle_ignore_done", DW'(done), DW'(1'b0));
    check("idle_ignore_rdata", rdata, '0);
    check("idle_ignore_req", DW'(sd_bus.sd_req), DW'(1'b0));

    // T1: line read at 0x000123, ack after 3 cycles
    issue(1'b0, 1'b1, 25'h0000123, 4'h0, '0, 1'b0, 1'b1,
          128'h44444444_33333333_22222222_11111111);
    check("t1_addr", DW'(sd_bus.sd_addr), DW'(25'h0000120));
    check("t1_bcnt", DW'(sd_bus.sd_burst_cnt), DW'(4'd4));
    check("t1_be", DW'(sd_bus.sd_be), DW'(4'hF));
    check("t1_wr", DW'(sd_bus.sd_wr), DW'(1'b0));
    beat(32'hFFFFFFFF, 1'b1);   // ignored while in REQ
    tick();
    check("t1_req_hold", DW'(sd_bus.sd_req), DW'(1'b1));
    check("t1_addr_hold", DW'(sd_bus.sd_addr), DW'(25'h0000120));
    check("t1_no_done_in_req", DW'(done), DW'(1'b0));
    ack_now();
    for (int i = 0; i < 4; i++) beat(32'(32'h11111111 * (i + 1)), (i == 3));
    expect_done("t1");

    // T2: single-word masked write, back-to-back with T1
    issue(1'b1, 1'b0, 25'h1000006, 4'b0011, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_DEADBEEF,
          1'b0, 1'b0, '0);
    check("t2_addr", DW'(sd_bus.sd_addr), DW'(25'h1000004));
    check("t2_be", DW'(sd_bus.sd_be), DW'(4'b0011));
    check("t2_bcnt", DW'(sd_bus.sd_burst_cnt), DW'(4'd1));
    check("t2_wr", DW'(sd_bus.sd_wr), DW'(1'b1));
    check("t2_din", DW'(sd_bus.sd_din), DW'(32'hDEADBEEF));
    ack_now();
    tick();
    tick();
    check("t2_din_hold", DW'(sd_bus.sd_din), DW'(32'hDEADBEEF));
    beat(32'h0, 1'b1);
    expect_done("t2");

    // T3: line write with ready gaps on cycles 1, 4, 5, 9
    for (int i = 0; i < 4; i++) w[i] = 32'hC0DE0000 + 32'(i);
    issue(1'b1, 1'b1, 25'h00ABCDE, 4'h0, {w[3], w[2], w[1], w[0]}, 1'b0, 1'b0, '0);
    check("t3_addr", DW'(sd_bus.sd_addr), DW'(25'h00ABCD0));
    check("t3_be", DW'(sd_bus.sd_be), DW'(4'hF));
    ack_now();
    k = 0;
    for (int c = 1; c <= 9; c++) begin
      check("t3_din_step", DW'(sd_bus.sd_din), DW'(w[k]));
      if (c == 1 || c == 4 || c == 5 || c == 9) begin
        sd_bus.sd_ready      = 1'b1;
        sd_bus.sd_burst_done = (c == 9);
        k++;
      end
      tick();
      sd_bus.sd_ready      = 1'b0;
      sd_bus.sd_burst_done = 1'b0;
    end
    expect_done("t3");

    // T4a: burst_done after only 2 of 4 words
    issue(1'b0, 1'b1, 25'h0000200, 4'h0, '0, 1'b1, 1'b0, '0);
    ack_now();
    beat(32'h12345678, 1'b0);
    beat(32'h9ABCDEF0, 1'b1);
    expect_done("t4a_short");

    // T4b: fifth ready is ignored but flags err
    issue(1'b0, 1'b1, 25'h0000300, 4'h0, '0, 1'b1, 1'b1,
          128'hA0000003_A0000002_A0000001_A0000000);
    ack_now();
    for (int i = 0; i < 5; i++) beat(32'hA0000000 + 32'(i), (i == 4));
    expect_done("t4b_extra");

    // T5: reset in XFER after 2 words, then a clean transfer
    issue(1'b0, 1'b1, 25'h0000400, 4'h0, '0, 1'b0, 1'b0, '0);
    ack_now();
    beat(32'h01010101, 1'b0);
    beat(32'h02020202, 1'b0);
    reset = 1'b1;
    #1;
    check("t5_rst_req", DW'(sd_bus.sd_req), DW'(1'b0));
    check("t5_rst_cmd_ready", DW'(cmd_ready), DW'(1'b1));
    check("t5_rst_done", DW'(done), DW'(1'b0));
    sb.delete();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_done", DW'(done), DW'(1'b0));
    end
    issue(1'b0, 1'b1, 25'h0000500, 4'h0, '0, 1'b0, 1'b1,
          128'h55555554_55555553_55555552_55555551);
    ack_now();
    for (int i = 0; i < 4; i++) beat(32'h55555551 + 32'(i), (i == 3));
    expect_done("t5_after");

    // T6: ack never arrives
`ifdef SDRAM_LINE_MASTER_TIMEOUT_EN
    issue(1'b0, 1'b1, 25'h0000600, 4'h0, '0, 1'b1, 1'b0, '0);
    n = 0;
    while (sd_bus.sd_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("t6_req_cycles", DW'(n), DW'(15));
    expect_done("t6_timeout");
`else
    issue(1'b0, 1'b1, 25'h0000600, 4'h0, '0, 1'b0, 1'b0, '0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("t6_req_stays", DW'(sd_bus.sd_req), DW'(1'b1));
      check("t6_no_done", DW'(done), DW'(1'b0));
    end
    reset = 1'b1;
    #1;
    check("t6_rst_req", DW'(sd_bus.sd_req), DW'(1'b0));
    check("t6_rst_cmd_ready", DW'(cmd_ready), DW'(1'b1));
    sb.delete();
    tick();
    reset = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
